// File: rtl/comp_stream_n.sv
// -----------------------------------------------------------------------------
// comp_stream_n
//   Registered, streaming N-bit magnitude comparator. Operand pairs (a,b) are
//   accepted over a valid/ready handshake and compared in signed or unsigned
//   mode; the L/G/E flags appear one cycle after acceptance. Saturating
//   per-outcome event counters and an equal-run tracker (eq_streak) are kept
//   alongside the result.
//
//   Optional feature macro: COMP_STREAM_MINMAX_EN
//     When defined, adds min_a / max_a / minmax_valid, which track the smallest
//     and largest accepted operand A since reset or clr.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset (overrides clr)
//   in_valid     operand pair valid
//   in_ready     block can accept a pair this cycle
//   a, b         operands (N bits)
//   signed_mode  1 = two's-complement compare, 0 = unsigned
//   clr          synchronous clear of counters, run tracker (and min/max)
//   out_valid    L/G/E hold a result
//   out_ready    consumer accepts the result
//   L, G, E      a < b, a > b, a == b
//   cnt_lt/gt/eq saturating counts of accepted outcomes since reset/clr
//   eq_streak    consecutive equal results reached RUN_TH
//   min_a/max_a/minmax_valid  (COMP_STREAM_MINMAX_EN only)
// -----------------------------------------------------------------------------
module comp_stream_n #(
   parameter int N      = 32,
   parameter int CNT_W  = 16,
   parameter int RUN_TH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     a,
   input  logic [N-1:0]     b,
   input  logic             signed_mode,
   input  logic             clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             L,
   output logic             G,
   output logic             E,
   output logic [CNT_W-1:0] cnt_lt,
   output logic [CNT_W-1:0] cnt_gt,
   output logic [CNT_W-1:0] cnt_eq,
`ifdef COMP_STREAM_MINMAX_EN
   output logic [N-1:0]     min_a,
   output logic [N-1:0]     max_a,
   output logic             minmax_valid,
`endif
   output logic             eq_streak
);

   typedef enum logic [1:0] {
      OUT_LT = 2'd0,
      OUT_GT = 2'd1,
      OUT_EQ = 2'd2
   } outcome_t;

   localparam logic [CNT_W-1:0] RUN_LIM = CNT_W'(RUN_TH);

   // Flipping the MSB in signed mode maps two's-complement order onto
   // unsigned order, so one unsigned comparator serves both modes.
   function automatic logic [N-1:0] order_key(input logic [N-1:0] x,
                                              input logic sm);
      return {x[N-1] ^ sm, x[N-2:0]};
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + CNT_W'(1);
   endfunction

   logic             accept;
   logic [N-1:0]     a_key;
   logic [N-1:0]     b_key;
   outcome_t         outcome;
   logic [CNT_W-1:0] run;
   logic [CNT_W-1:0] run_next;

   // Single output register: a new pair may enter whenever the held result
   // leaves in the same cycle.
   always_comb begin
      in_ready = !out_valid || out_ready;
      accept   = in_valid && in_ready;
   end

   always_comb begin
      a_key   = order_key(a, signed_mode);
      b_key   = order_key(b, signed_mode);
      outcome = OUT_EQ;
      if (a_key < b_key)
         outcome = OUT_LT;
      else if (a_key > b_key)
         outcome = OUT_GT;
   end

   always_comb begin
      run_next = '0;
      if (outcome == OUT_EQ)
         run_next = (run == RUN_LIM) ? run : run + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         L         <= 1'b0;
         G         <= 1'b0;
         E         <= 1'b0;
         cnt_lt    <= '0;
         cnt_gt    <= '0;
         cnt_eq    <= '0;
         run       <= '0;
         eq_streak <= 1'b0;
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            L         <= (outcome == OUT_LT);
            G         <= (outcome == OUT_GT);
            E         <= (outcome == OUT_EQ);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         // clr takes priority: a pair accepted in the same cycle still
         // produces L/G/E above but is not counted here.
         if (clr) begin
            cnt_lt    <= '0;
            cnt_gt    <= '0;
            cnt_eq    <= '0;
            run       <= '0;
            eq_streak <= 1'b0;
         end else if (accept) begin
            case (outcome)
               OUT_LT:  cnt_lt <= sat_inc(cnt_lt);
               OUT_GT:  cnt_gt <= sat_inc(cnt_gt);
               default: cnt_eq <= sat_inc(cnt_eq);
            endcase
            run       <= run_next;
            eq_streak <= (run_next == RUN_LIM);
         end
      end
   end

`ifdef COMP_STREAM_MINMAX_EN
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         min_a        <= '0;
         max_a        <= '0;
         minmax_valid <= 1'b0;
      end else if (accept) begin
         if (!minmax_valid) begin
            min_a        <= a;
            max_a        <= a;
            minmax_valid <= 1'b1;
         end else begin
            if (a_key < order_key(min_a, signed_mode))
               min_a <= a;
            if (a_key > order_key(max_a, signed_mode))
               max_a <= a;
         end
      end
   end
`endif

endmodule

// File: tb/tb_comp_stream_n.sv
module tb_comp_stream_n;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       clr = 1'b0;
   logic       in_valid = 1'b0;
   logic       signed_mode = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;

   logic [1:0]  irdy, ovld, o_l, o_g, o_e, ostk;
   logic [15:0] c0_lt, c0_gt, c0_eq;
   logic [1:0]  c1_lt, c1_gt, c1_eq;
`ifdef COMP_STREAM_MINMAX_EN
   logic [7:0]  mina0, maxa0, mina1, maxa1;
   logic [1:0]  mmv;
`endif

   int tests  = 0;
   int failed = 0;

   // Two instances share all inputs: wide counters with RUN_TH=4, and
   // 2-bit counters (RUN_TH=3) to reach saturation quickly.
   comp_stream_n #(.N(8), .CNT_W(16), .RUN_TH(4)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[0]),
      .a(a), .b(b), .signed_mode(signed_mode), .clr(clr),
      .out_valid(ovld[0]), .out_ready(out_ready),
      .L(o_l[0]), .G(o_g[0]), .E(o_e[0]),
      .cnt_lt(c0_lt), .cnt_gt(c0_gt), .cnt_eq(c0_eq),
`ifdef COMP_STREAM_MINMAX_EN
      .min_a(mina0), .max_a(maxa0), .minmax_valid(mmv[0]),
`endif
      .eq_streak(ostk[0]));

   comp_stream_n #(.N(8), .CNT_W(2), .RUN_TH(3)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(irdy[1]),
      .a(a), .b(b), .signed_mode(signed_mode), .clr(clr),
      .out_valid(ovld[1]), .out_ready(out_ready),
      .L(o_l[1]), .G(o_g[1]), .E(o_e[1]),
      .cnt_lt(c1_lt), .cnt_gt(c1_gt), .cnt_eq(c1_eq),
`ifdef COMP_STREAM_MINMAX_EN
      .min_a(mina1), .max_a(maxa1), .minmax_valid(mmv[1]),
`endif
      .eq_streak(ostk[1]));

   // Reference model: outcome index 0=LT, 1=GT, 2=EQ.
   int         cmax[2] = '{65535, 3};
   int         th[2]   = '{4, 3};
   int         m_v[2], m_l[2], m_g[2], m_e[2];
   int         m_cnt[2][3];
   int         m_run[2], m_stk[2], m_mmv[2];
   logic [7:0] m_min[2], m_max[2];

   function automatic int val(input logic [7:0] x, input logic sm);
      if (sm) return int'($signed(x));
      return int'(x);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      int va, vb, o;
      bit acc;
      va = val(a, signed_mode);
      vb = val(b, signed_mode);
      o  = (va < vb) ? 0 : (va > vb) ? 1 : 2;
      for (int k = 0; k < 2; k++) begin
         acc = in_valid && (m_v[k] == 0 || out_ready);
         if (rst) begin
            m_v[k] = 0; m_l[k] = 0; m_g[k] = 0; m_e[k] = 0;
            for (int j = 0; j < 3; j++) m_cnt[k][j] = 0;
            m_run[k] = 0; m_stk[k] = 0; m_mmv[k] = 0;
            m_min[k] = '0; m_max[k] = '0;
         end else begin
            if (acc) begin
               m_v[k] = 1;
               m_l[k] = (o == 0) ? 1 : 0;
               m_g[k] = (o == 1) ? 1 : 0;
               m_e[k] = (o == 2) ? 1 : 0;
            end else if (out_ready) begin
               m_v[k] = 0;
            end
            if (clr) begin
               for (int j = 0; j < 3; j++) m_cnt[k][j] = 0;
               m_run[k] = 0; m_stk[k] = 0; m_mmv[k] = 0;
               m_min[k] = '0; m_max[k] = '0;
            end else if (acc) begin
               if (m_cnt[k][o] < cmax[k]) m_cnt[k][o] = m_cnt[k][o] + 1;
               if (o == 2) m_run[k] = (m_run[k] < th[k]) ? m_run[k] + 1 : th[k];
               else        m_run[k] = 0;
               m_stk[k] = (m_run[k] == th[k]) ? 1 : 0;
               if (m_mmv[k] == 0) begin
                  m_min[k] = a; m_max[k] = a; m_mmv[k] = 1;
               end else begin
                  if (va < val(m_min[k], signed_mode)) m_min[k] = a;
                  if (va > val(m_max[k], signed_mode)) m_max[k] = a;
               end
            end
         end
      end
   endtask

   task automatic check_outs();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("out_valid%0d", k), 32'(ovld[k]), m_v[k]);
         if (m_v[k] != 0) begin
            chk($sformatf("L%0d", k), 32'(o_l[k]), m_l[k]);
            chk($sformatf("G%0d", k), 32'(o_g[k]), m_g[k]);
            chk($sformatf("E%0d", k), 32'(o_e[k]), m_e[k]);
         end
         chk($sformatf("cnt_lt%0d", k), (k == 0) ? 32'(c0_lt) : 32'(c1_lt), m_cnt[k][0]);
         chk($sformatf("cnt_gt%0d", k), (k == 0) ? 32'(c0_gt) : 32'(c1_gt), m_cnt[k][1]);
         chk($sformatf("cnt_eq%0d", k), (k == 0) ? 32'(c0_eq) : 32'(c1_eq), m_cnt[k][2]);
         chk($sformatf("eq_streak%0d", k), 32'(ostk[k]), m_stk[k]);
`ifdef COMP_STREAM_MINMAX_EN
         chk($sformatf("minmax_valid%0d", k), 32'(mmv[k]), m_mmv[k]);
         chk($sformatf("min_a%0d", k), (k == 0) ? 32'(mina0) : 32'(mina1), 32'(m_min[k]));
         chk($sformatf("max_a%0d", k), (k == 0) ? 32'(maxa0) : 32'(maxa1), 32'(m_max[k]));
`endif
      end
   endtask

   // Inputs are already applied; check in_ready, clock once, check outputs.
   task automatic cycle();
      #1;
      for (int k = 0; k < 2; k++)
         chk($sformatf("in_ready%0d", k), 32'(irdy[k]),
             (m_v[k] == 0 || out_ready) ? 32'd1 : 32'd0);
      @(posedge clk);
      model_edge();
      #1;
      check_outs();
   endtask

   task automatic step(input logic r, input logic c, input logic iv,
                       input logic [7:0] aa, input logic [7:0] bb,
                       input logic sm, input logic orr);
      rst = r; clr = c; in_valid = iv; a = aa; b = bb;
      signed_mode = sm; out_ready = orr;
      cycle();
   endtask

   initial begin
      // Reset (DUT state unknown before first edge, so no in_ready check).
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         model_edge();
         #1;
         check_outs();
      end

      // Unsigned LT, GT, EQ back to back.
      step(0, 0, 1, 8'd5, 8'd9, 0, 1);  chk("seq_L", 32'(o_l[0]), 32'd1);
      step(0, 0, 1, 8'd9, 8'd5, 0, 1);  chk("seq_G", 32'(o_g[0]), 32'd1);
      step(0, 0, 1, 8'd7, 8'd7, 0, 1);  chk("seq_E", 32'(o_e[0]), 32'd1);
      chk("seq_cnt_lt", 32'(c0_lt), 32'd1);
      chk("seq_cnt_gt", 32'(c0_gt), 32'd1);
      chk("seq_cnt_eq", 32'(c0_eq), 32'd1);

      // Signed vs unsigned interpretation of 0x80 against 0x01.
      step(0, 0, 1, 8'h80, 8'h01, 1, 1); chk("signed_L", 32'(o_l[0]), 32'd1);
      step(0, 0, 1, 8'h80, 8'h01, 0, 1); chk("unsigned_G", 32'(o_g[0]), 32'd1);
      step(0, 0, 0, 8'h00, 8'h00, 0, 1); chk("drain", 32'(ovld[0]), 32'd0);

      // Backpressure: one accept then a 5-cycle stall, then streaming.
      step(0, 0, 1, 8'd3, 8'd1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(0, 0, 1, 8'd1, 8'd9, 0, 0);
         chk("stall_G", 32'(o_g[0]), 32'd1);
         chk("stall_ready", 32'(irdy[0]), 32'd0);
      end
      step(0, 0, 1, 8'd1, 8'd9, 0, 1);  chk("bp_L", 32'(o_l[0]), 32'd1);
      step(0, 0, 1, 8'd4, 8'd4, 0, 1);  chk("bp_E", 32'(o_e[0]), 32'd1);
      step(0, 0, 1, 8'd9, 8'd2, 0, 1);  chk("bp_G", 32'(o_g[0]), 32'd1);

      // Equal run: streak rises after the 4th EQ, falls after the LT.
      step(0, 1, 0, 8'd0, 8'd0, 0, 1);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, 8'd6, 8'd6, 0, 1);
         chk("streak_rise", 32'(ostk[0]), (i == 3) ? 32'd1 : 32'd0);
      end
      step(0, 0, 1, 8'd1, 8'd6, 0, 1);  chk("streak_fall", 32'(ostk[0]), 32'd0);

      // Counter saturation on the 2-bit instance, then clr with an accept.
      step(0, 1, 0, 8'd0, 8'd0, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 1, 8'd2, 8'd200, 0, 1);
      chk("sat_cnt_lt", 32'(c1_lt), 32'd3);
      step(0, 1, 1, 8'd9, 8'd2, 0, 1);
      chk("clr_cnt_gt", 32'(c1_gt), 32'd0);
      chk("clr_cnt_lt", 32'(c1_lt), 32'd0);
      chk("clr_valid", 32'(ovld[1]), 32'd1);
      chk("clr_G", 32'(o_g[1]), 32'd1);

      // Reset while a result is stalled.
      step(0, 0, 1, 8'd1, 8'd1, 0, 1);
      step(0, 0, 1, 8'd3, 8'd1, 0, 0);
      step(1, 0, 1, 8'd3, 8'd1, 0, 0);
      chk("rst_valid", 32'(ovld[0]), 32'd0);
      chk("rst_cnt_eq", 32'(c0_eq), 32'd0);
      chk("rst_ready", 32'(irdy[0]), 32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
         step(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
              1'($urandom_range(0, 1)),
              ra, rb,
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
